// File: rtl/constant_monitor_if.sv
// ----------------------------------------------------------------------------
// constant_monitor_if
// Groups the rail inputs, the controls and the status outputs of
// constant_monitor.
//   one_i      : buffered constant-high rail under test (asynchronous)
//   zero_i     : buffered constant-low rail under test (asynchronous)
//   enable     : monitor enable, level
//   clear      : single-cycle pulse; clears fault, code and counters, restarts holdoff
//   fault      : sticky fault flag
//   fault_code : bit0 = one seen low, bit1 = zero seen high (faulting run)
//   err_count  : saturating count of bad samples taken while monitoring
//   monitor_ok : monitoring, with an empty bad run
//   irq        : one-cycle pulse on fault entry
// Modports: master drives the rails and controls; slave is the monitor.
// ----------------------------------------------------------------------------
interface constant_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             one_i;
    logic             zero_i;
    logic             enable;
    logic             clear;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] err_count;
    logic             monitor_ok;
    logic             irq;

    modport master (
        output one_i, zero_i, enable, clear,
        input  fault, fault_code, err_count, monitor_ok, irq
    );

    modport slave (
        input  one_i, zero_i, enable, clear,
        output fault, fault_code, err_count, monitor_ok, irq
    );
endinterface

// File: rtl/constant_monitor.sv
// ----------------------------------------------------------------------------
// constant_monitor
// Watches the one/zero tie-off rails. Both rails are synchronized. After a
// holdoff period, a sticky fault is declared when THRESH consecutive
// synchronized samples are bad.
// Ports:
//   clk    : block clock
//   resetb : asynchronous active-low reset
//   bus    : constant_monitor_if.slave (rails, enable/clear, status outputs)
// Parameters: HOLDOFF (holdoff cycles, >=1), THRESH (bad run length that
//   declares a fault, >=1), CNT_W (width of the saturating error counter).
// Build option: define CONST_MON_IRQ_EN to build the irq pulse. Without it
//   irq is tied to 0.
// ----------------------------------------------------------------------------
module constant_monitor #(
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned THRESH  = 4,
    parameter int unsigned CNT_W   = 8
) (
    input logic               clk,
    input logic               resetb,
    constant_monitor_if.slave bus
);

    localparam int unsigned HoldW = $clog2(HOLDOFF + 1);
    localparam int unsigned RunW  = $clog2(THRESH + 1);

    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);
    localparam logic [RunW-1:0]  RunLast  = RunW'(THRESH - 1);
    localparam logic [CNT_W-1:0] ErrMax   = '1;

    typedef enum logic [1:0] {
        StHoldoff = 2'd0,
        StMonitor = 2'd1,
        StFault   = 2'd2,
        StIdle    = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizers. They reset to the good level of each rail, so reset
    // never shows up as a bad sample.
    // ------------------------------------------------------------------
    logic r_one_s1, r_one_s2;
    logic r_zero_s1, r_zero_s2;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_one_s1  <= 1'b1;
            r_one_s2  <= 1'b1;
            r_zero_s1 <= 1'b0;
            r_zero_s2 <= 1'b0;
        end else begin
            r_one_s1  <= bus.one_i;
            r_one_s2  <= r_one_s1;
            r_zero_s1 <= bus.zero_i;
            r_zero_s2 <= r_zero_s1;
        end
    end

    logic [1:0] w_bad_type;   // {zero seen high, one seen low}
    logic       w_bad;

    assign w_bad_type = {r_zero_s2, ~r_one_s2};
    assign w_bad      = |w_bad_type;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e           r_state, w_state_nxt;
    logic [HoldW-1:0] r_hold, w_hold_nxt;
    logic [RunW-1:0]  r_run, w_run_nxt;
    logic [1:0]       r_rtype, w_rtype_nxt;
    logic [CNT_W-1:0] r_err, w_err_nxt;
    logic [1:0]       r_code, w_code_nxt;
    logic             r_fault, w_fault_nxt;
    logic             r_ok, w_ok_nxt;
    logic             w_fault_hit;

    // THRESH-th consecutive bad sample while monitoring
    assign w_fault_hit = (r_state == StMonitor) && w_bad && (r_run == RunLast);

    // State register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= StHoldoff;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. clear wins over everything; fault entry wins over
    // enable=0.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = bus.enable ? StHoldoff : StIdle;
        end else begin
            case (r_state)
                StHoldoff: begin
                    if (!bus.enable) begin
                        w_state_nxt = StIdle;
                    end else if (r_hold == HoldLast) begin
                        w_state_nxt = StMonitor;
                    end
                end
                StMonitor: begin
                    if (w_fault_hit) begin
                        w_state_nxt = StFault;
                    end else if (!bus.enable) begin
                        w_state_nxt = StIdle;
                    end
                end
                StFault: begin
                    w_state_nxt = StFault;
                end
                StIdle: begin
                    if (bus.enable) begin
                        w_state_nxt = StHoldoff;
                    end
                end
                default: begin
                    w_state_nxt = StHoldoff;
                end
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        w_hold_nxt  = '0;
        w_run_nxt   = r_run;
        w_rtype_nxt = r_rtype;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;
        w_fault_nxt = r_fault;

        if (bus.clear) begin
            w_run_nxt   = '0;
            w_rtype_nxt = '0;
            w_err_nxt   = '0;
            w_code_nxt  = '0;
            w_fault_nxt = 1'b0;
        end else begin
            // Holdoff counter only runs while staying in holdoff; any other
            // path resets it so the next holdoff starts from zero.
            if ((r_state == StHoldoff) && (w_state_nxt == StHoldoff)) begin
                w_hold_nxt = r_hold + HoldW'(1);
            end

            if (r_state == StMonitor) begin
                if (w_bad) begin
                    if (r_err != ErrMax) begin
                        w_err_nxt = r_err + CNT_W'(1);
                    end
                    if (w_fault_hit) begin
                        w_code_nxt  = r_rtype | w_bad_type;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_run_nxt   = r_run + RunW'(1);
                        w_rtype_nxt = r_rtype | w_bad_type;
                    end
                end else begin
                    w_run_nxt   = '0;
                    w_rtype_nxt = '0;
                end

                if (w_state_nxt == StIdle) begin
                    w_run_nxt   = '0;
                    w_rtype_nxt = '0;
                end
            end
        end

        w_ok_nxt = (w_state_nxt == StMonitor) && (w_run_nxt == '0);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_hold  <= '0;
            r_run   <= '0;
            r_rtype <= '0;
            r_err   <= '0;
            r_code  <= '0;
            r_fault <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_hold  <= w_hold_nxt;
            r_run   <= w_run_nxt;
            r_rtype <= w_rtype_nxt;
            r_err   <= w_err_nxt;
            r_code  <= w_code_nxt;
            r_fault <= w_fault_nxt;
            r_ok    <= w_ok_nxt;
        end
    end

`ifdef CONST_MON_IRQ_EN
    logic r_irq;
    logic w_irq_nxt;

    // High only in the first cycle of fault=1
    assign w_irq_nxt = w_fault_hit && !bus.clear;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_nxt;
        end
    end

    assign bus.irq = r_irq;
`else
    assign bus.irq = 1'b0;
`endif

    assign bus.fault      = r_fault;
    assign bus.fault_code = r_code;
    assign bus.err_count  = r_err;
    assign bus.monitor_ok = r_ok;

endmodule

// File: tb/tb_constant_monitor.sv
// ----------------------------------------------------------------------------
// tb_constant_monitor
// Directed bench for constant_monitor. DUT A uses the default parameters.
// DUT B (HOLDOFF=2, THRESH=300) exercises saturation of err_count. A
// behavioural model for each DUT is compared with the outputs on every
// falling edge. Literal expectations at key points pin the model.
// ----------------------------------------------------------------------------
module tb_constant_monitor;

`ifdef CONST_MON_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif

    localparam int ModeHold  = 0;
    localparam int ModeMon   = 1;
    localparam int ModeFault = 2;
    localparam int ModeIdle  = 3;

    typedef struct {
        bit       s1o, s2o, s1z, s2z;
        int       mode;
        int       hcnt;
        int       run;
        bit [1:0] rtype;
        bit       fault;
        bit [1:0] code;
        int       err;
        bit       ok;
        bit       irq;
    } mdl_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    constant_monitor_if #(.CNT_W(8)) a_if ();
    constant_monitor_if #(.CNT_W(8)) b_if ();

    constant_monitor #(.HOLDOFF(16), .THRESH(4), .CNT_W(8)) u_dut_a (
        .clk    (clk),
        .resetb (resetb),
        .bus    (a_if.slave)
    );

    constant_monitor #(.HOLDOFF(2), .THRESH(300), .CNT_W(8)) u_dut_b (
        .clk    (clk),
        .resetb (resetb),
        .bus    (b_if.slave)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.s1o = 1'b1; m.s2o = 1'b1; m.s1z = 1'b0; m.s2z = 1'b0;
        m.mode = ModeHold; m.hcnt = 0; m.run = 0; m.rtype = 2'b00;
        m.fault = 1'b0; m.code = 2'b00; m.err = 0; m.ok = 1'b0; m.irq = 1'b0;
        return m;
    endfunction

    // One clock of the spec's behaviour
    function automatic mdl_t mdl_step(mdl_t m, bit one_in, bit zero_in, bit en, bit clr,
                                      int hold, int thr, int emax);
        mdl_t     n;
        bit [1:0] bad;
        n   = m;
        bad = {m.s2z, ~m.s2o};
        n.s1o = one_in;  n.s2o = m.s1o;
        n.s1z = zero_in; n.s2z = m.s1z;
        n.irq = 1'b0;
        if (clr) begin
            n.mode = en ? ModeHold : ModeIdle;
            n.hcnt = 0; n.run = 0; n.rtype = 2'b00;
            n.fault = 1'b0; n.code = 2'b00; n.err = 0;
        end else begin
            case (m.mode)
                ModeHold: begin
                    if (!en) begin
                        n.mode = ModeIdle;
                        n.hcnt = 0;
                    end else begin
                        n.hcnt = m.hcnt + 1;
                        if (n.hcnt == hold) begin
                            n.mode = ModeMon;
                            n.hcnt = 0;
                        end
                    end
                end
                ModeMon: begin
                    if (bad != 2'b00) begin
                        n.err   = (m.err + 1 > emax) ? emax : m.err + 1;
                        n.run   = m.run + 1;
                        n.rtype = m.rtype | bad;
                        if (n.run == thr) begin
                            n.mode  = ModeFault;
                            n.fault = 1'b1;
                            n.code  = n.rtype;
                            n.irq   = 1'b1;
                        end
                    end else begin
                        n.run   = 0;
                        n.rtype = 2'b00;
                    end
                    if (n.mode == ModeMon && !en) begin
                        n.mode  = ModeIdle;
                        n.run   = 0;
                        n.rtype = 2'b00;
                    end
                end
                ModeFault: begin
                end
                default: begin
                    if (en) begin
                        n.mode = ModeHold;
                        n.hcnt = 0;
                    end
                end
            endcase
        end
        n.ok = (n.mode == ModeMon) && (n.run == 0);
        return n;
    endfunction

    mdl_t ma, mb;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, a_if.one_i, a_if.zero_i, a_if.enable, a_if.clear, 16, 4, 255);
            mb <= mdl_step(mb, b_if.one_i, b_if.zero_i, b_if.enable, b_if.clear, 2, 300, 255);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the models
    always @(negedge clk) begin
        chk("a.fault", 32'(a_if.fault), 32'(ma.fault));
        chk("a.fault_code", 32'(a_if.fault_code), 32'(ma.code));
        chk("a.err_count", 32'(a_if.err_count), 32'(ma.err));
        chk("a.monitor_ok", 32'(a_if.monitor_ok), 32'(ma.ok));
        chk("a.irq", 32'(a_if.irq), 32'(ma.irq & IrqOn));
        chk("b.fault", 32'(b_if.fault), 32'(mb.fault));
        chk("b.err_count", 32'(b_if.err_count), 32'(mb.err));
        chk("b.monitor_ok", 32'(b_if.monitor_ok), 32'(mb.ok));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        a_if.one_i = 1'b1; a_if.zero_i = 1'b0; a_if.enable = 1'b1; a_if.clear = 1'b0;
        b_if.one_i = 1'b1; b_if.zero_i = 1'b0; b_if.enable = 1'b1; b_if.clear = 1'b0;

        // Reset values
        tick(3);
        chk("lit.reset.fault", 32'(a_if.fault), 32'd0);
        chk("lit.reset.code", 32'(a_if.fault_code), 32'd0);
        chk("lit.reset.err", 32'(a_if.err_count), 32'd0);
        chk("lit.reset.ok", 32'(a_if.monitor_ok), 32'd0);
        chk("lit.reset.irq", 32'(a_if.irq), 32'd0);

        // Holdoff: monitor_ok rises after rising edge 16
        resetb = 1'b1;
        tick(15);
        chk("lit.holdoff.ok15", 32'(a_if.monitor_ok), 32'd0);
        tick(1);
        chk("lit.holdoff.ok16", 32'(a_if.monitor_ok), 32'd1);
        tick(84);
        chk("lit.idle_rails.fault", 32'(a_if.fault), 32'd0);
        chk("lit.idle_rails.err", 32'(a_if.err_count), 32'd0);

        // Short bad run of 3 on one: no fault
        a_if.one_i = 1'b0;
        tick(3);
        a_if.one_i = 1'b1;
        tick(1);
        chk("lit.run3.ok_drop", 32'(a_if.monitor_ok), 32'd0);
        tick(4);
        chk("lit.run3.err", 32'(a_if.err_count), 32'd3);
        chk("lit.run3.fault", 32'(a_if.fault), 32'd0);
        chk("lit.run3.ok", 32'(a_if.monitor_ok), 32'd1);

        // zero stuck high: fault after edge k+5
        a_if.zero_i = 1'b1;
        tick(5);
        chk("lit.zero.fault_early", 32'(a_if.fault), 32'd0);
        tick(1);
        chk("lit.zero.fault", 32'(a_if.fault), 32'd1);
        chk("lit.zero.code", 32'(a_if.fault_code), 32'd2);
        chk("lit.zero.irq", 32'(a_if.irq), 32'(IrqOn));
        chk("lit.zero.err", 32'(a_if.err_count), 32'd7);
        tick(1);
        chk("lit.zero.irq_end", 32'(a_if.irq), 32'd0);
        a_if.zero_i = 1'b0;
        tick(10);
        chk("lit.zero.sticky", 32'(a_if.fault), 32'd1);
        chk("lit.zero.err_frozen", 32'(a_if.err_count), 32'd7);

        // Clear, then holdoff of 16
        a_if.clear = 1'b1;
        tick(1);
        a_if.clear = 1'b0;
        chk("lit.clear.fault", 32'(a_if.fault), 32'd0);
        chk("lit.clear.code", 32'(a_if.fault_code), 32'd0);
        chk("lit.clear.err", 32'(a_if.err_count), 32'd0);
        tick(15);
        chk("lit.clear.ok15", 32'(a_if.monitor_ok), 32'd0);
        tick(1);
        chk("lit.clear.ok16", 32'(a_if.monitor_ok), 32'd1);
        tick(4);

        // Clear coinciding with the 4th bad sample: no fault
        a_if.one_i = 1'b0;
        tick(5);
        a_if.clear = 1'b1;
        tick(1);
        a_if.clear = 1'b0;
        chk("lit.clear4.fault", 32'(a_if.fault), 32'd0);
        chk("lit.clear4.err", 32'(a_if.err_count), 32'd0);
        a_if.one_i = 1'b1;
        tick(24);
        chk("lit.clear4.ok", 32'(a_if.monitor_ok), 32'd1);

        // Drop enable with a bad run of 2 in progress
        a_if.one_i = 1'b0;
        tick(4);
        chk("lit.en.run2", 32'(a_if.monitor_ok), 32'd0);
        a_if.enable = 1'b0;
        tick(1);
        a_if.one_i = 1'b1;
        tick(3);
        a_if.enable = 1'b1;
        tick(1);
        tick(15);
        chk("lit.en.ok15", 32'(a_if.monitor_ok), 32'd0);
        tick(1);
        chk("lit.en.ok16", 32'(a_if.monitor_ok), 32'd1);
        // Two more bad samples would fault if the old run had survived
        a_if.one_i = 1'b0;
        tick(2);
        a_if.one_i = 1'b1;
        tick(6);
        chk("lit.en.nofault", 32'(a_if.fault), 32'd0);

        // Saturation on DUT B
        b_if.one_i = 1'b0;
        tick(300);
        chk("lit.sat.err", 32'(b_if.err_count), 32'd255);
        chk("lit.sat.fault", 32'(b_if.fault), 32'd0);
        b_if.one_i = 1'b1;
        tick(5);
        chk("lit.sat.hold", 32'(b_if.err_count), 32'd255);

        // Asynchronous reset in mid-cycle
        a_if.zero_i = 1'b1;
        tick(10);
        #3 resetb = 1'b0;
        #1;
        chk("lit.areset.fault", 32'(a_if.fault), 32'd0);
        chk("lit.areset.err", 32'(b_if.err_count), 32'd0);
        a_if.zero_i = 1'b0;
        tick(2);
        resetb = 1'b1;
        tick(3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
